// File: rtl/pc_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and decode.
// The sequencer is the master; the memory/decode side is the slave.
interface pc_fetch_sequencer_if;
    // instruction memory handshake
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // decode-side instruction presentation
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        stall;

    // redirect requests resolved by decode/execute
    logic        jump;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [15:0] branch_imm;

    // status
    logic        addr_error;
    logic [31:0] instr_count;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        output pc_plus4,
        input  stall,
        input  jump,
        input  jump_reg,
        input  jr_target,
        input  branch_taken,
        input  branch_imm,
        output addr_error,
        output instr_count
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  pc_plus4,
        output stall,
        output jump,
        output jump_reg,
        output jr_target,
        output branch_taken,
        output branch_imm,
        input  addr_error,
        input  instr_count
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer for the MIPS core.
// Holds the PC, fetches one word at a time over a req/ready handshake,
// presents the word to decode and picks the next PC from the sequential,
// branch, J-type or jump-register source once decode accepts it.
// Every bus output comes straight from a register, so no input reaches an
// output combinationally.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    pc_fetch_sequencer_if.master    bus
);

    // The PC is always word aligned; strip any stray low bits of the vector.
    localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] instr_pc_reg;
    logic [31:0] pc_plus4_reg;
    logic [31:0] count_reg;
    logic        imem_req_reg;
    logic        instr_valid_reg;
    logic        addr_error_reg;

    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    // Candidate targets are formed from the latched instruction and its
    // PC+4; only the redirect request bits come from outside.
    always_comb begin
        branch_offset = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
        jump_target   = {pc_plus4_reg[31:28], instr_reg[25:0], 2'b00};
        branch_target = pc_plus4_reg + branch_offset;
        jr_misaligned = (bus.jr_target[1:0] != 2'b00);
    end

    // Next-PC priority: jump register, then J-type, then taken branch,
    // otherwise fall through. No delay slot, so the fall-through word is
    // simply never fetched when a redirect wins.
    always_comb begin
        next_pc = pc_plus4_reg;
        if (bus.jump_reg) begin
            next_pc = {bus.jr_target[31:2], 2'b00};
        end else if (bus.jump) begin
            next_pc = jump_target;
        end else if (bus.branch_taken) begin
            next_pc = branch_target;
        end
    end

    // Sequencer FSM with all bus outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= 32'h0000_0000;
            instr_pc_reg    <= RESET_PC;
            pc_plus4_reg    <= RESET_PC + 32'd4;
            count_reg       <= 32'h0000_0000;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
            addr_error_reg  <= 1'b0;
        end else begin
            // addr_error is a single-cycle pulse; only an accepting ISSUE
            // edge can raise it.
            addr_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    state_reg    <= FETCH;
                    imem_req_reg <= 1'b1;
                end
                FETCH: begin
                    // Address stays on pc_reg until memory answers.
                    if (bus.imem_ready) begin
                        instr_reg       <= bus.imem_rdata;
                        instr_pc_reg    <= pc_reg;
                        pc_plus4_reg    <= pc_reg + 32'd4;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // While stalled every register holds, so redirects
                    // presented during a stall have no effect.
                    if (!bus.stall) begin
                        pc_reg          <= next_pc;
                        count_reg       <= count_reg + 32'd1;
                        addr_error_reg  <= bus.jump_reg && jr_misaligned;
                        instr_valid_reg <= 1'b0;
                        imem_req_reg    <= 1'b1;
                        state_reg       <= FETCH;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    imem_req_reg    <= 1'b0;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus from the registered state.
    always_comb begin
        bus.imem_req    = imem_req_reg;
        bus.imem_addr   = pc_reg;
        bus.instr_valid = instr_valid_reg;
        bus.instr       = instr_reg;
        bus.instr_pc    = instr_pc_reg;
        bus.pc_plus4    = pc_plus4_reg;
        bus.addr_error  = addr_error_reg;
        bus.instr_count = count_reg;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Sequences instruction fetch and next-PC selection for the MIPS core. Holds the program counter and issues word fetches to instruction memory over a req/ready handshake. Presents each fetched instruction to decode and selects the next PC from sequential, branch, J-type jump or jump-register sources. The J-type target is formed here as {PC+4[31:28], instr[25:0], 2'b00}, and a retired-instruction counter is maintained.

## Interface
- RESET_VECTOR, 32'h0040_0000, PC loaded on reset; low 2 bits must be 0
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request; high in FETCH state only
- imem_addr  out  32  fetch address (= PC register)
- imem_ready  in  1  memory returns imem_rdata this cycle; ignored unless imem_req=1
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instruction held for decode; high in ISSUE state only
- instr  out  32  latched instruction word
- instr_pc  out  32  address of instr
- stall  in  1  decode/execute not ready; sampled only in ISSUE
- jump  in  1  J/JAL taken for current instr (valid with instr_valid)
- jump_reg  in  1  JR/JALR taken for current instr
- jr_target  in  32  register-source target for jump_reg
- branch_taken  in  1  conditional branch resolved taken
- branch_imm  in  16  raw branch immediate (instr[15:0] or decoder copy)
- pc_plus4  out  32  instr_pc + 4, for link register writes
- addr_error  out  1  one-cycle pulse: jr_target[1:0] != 0 at accepted redirect
- instr_count  out  32  retired instruction count

## Operation
- States: IDLE, FETCH, ISSUE. Encoding is free.
- IDLE: entered on reset; lasts exactly one cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - If imem_ready: instr<=imem_rdata, instr_pc<=pc, then go to ISSUE.
  - Otherwise stay in FETCH, with address held stable.
- ISSUE: instr_valid=1.
  - stall=1: hold state and every output; redirect inputs are ignored.
  - stall=0: the instruction is accepted. Load pc with next_pc, increment instr_count, go to FETCH.
- next_pc priority (first true wins):
  - jump_reg: {jr_target[31:2], 2'b00}. addr_error pulses the next cycle if jr_target[1:0] != 0.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch_taken: pc_plus4 + ({{14{branch_imm[15]}}, branch_imm, 2'b00}).
  - else pc_plus4.
- Multiple redirects asserted together: priority applies, with no error flag except the jr alignment case.
- Arithmetic is 32-bit modulo. PC 32'hFFFF_FFFC + 4 wraps to 0. Branch offset addition wraps likewise.
- instr_count wraps from 32'hFFFF_FFFF to 0.
- No branch delay slot: the instruction after a taken redirect is never fetched.

## Timing
- Reset values: state IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4, addr_error=0, instr_count=0.
- Reset wins over every other input in the same cycle. Reset asserted mid-FETCH or mid-ISSUE restores reset values on the next edge and drops any pending fetch.
- First imem_req occurs 2 cycles after the edge sampling reset=1, with reset deasserted (IDLE, then FETCH).
- Best case is 2 cycles per instruction (FETCH with imem_ready=1, then ISSUE with stall=0). Each imem_ready=0 cycle adds 1; each stall cycle adds 1.
- imem_req, imem_addr, instr_valid, instr, instr_pc and pc_plus4 are registered or decoded from registered state only. There is no combinational path from inputs.
- Redirect inputs are sampled only on the accepting ISSUE edge (instr_valid=1, stall=0). The new PC appears on imem_addr the following cycle.
- imem_ready arriving in any non-FETCH state is ignored.

## Test plan
- Sequential: reset, memory always ready → imem_addr sequence 0x00400000, 0x00400004, 0x00400008. instr_valid asserts every other cycle. instr_count=3 after 3 accepts.
- J-type: at pc 0x00400010, instr=0x0810_0040 with jump=1 → next imem_addr=0x00400100. pc_plus4=0x00400014 during ISSUE.
- Branch: at pc 0x00400020, branch_taken=1, branch_imm=16'hFFFE → next imem_addr=0x0040001C. With branch_imm=16'h0003 → 0x00400030.
- Priority/JR: jump_reg=1, jump=1, branch_taken=1, jr_target=0x00401007 → next imem_addr=0x00401004 and a single-cycle addr_error=1.
- Handshake: imem_ready low for 3 FETCH cycles, then stall high for 2 ISSUE cycles → imem_addr stable throughout. Redirects asserted during stall are ignored. One instr_count increment at release.
- Reset mid-ISSUE with stall=1 → next cycle all outputs at reset values, instr_count=0. First imem_req follows 2 cycles after reset drops.
